bist_controller: RTL and testbench
==================================

# bist_controller

Sequencer for the Booth-multiplier built-in self-test. It seeds and steps the 8-bit pattern LFSR and launches one multiplication per pattern. Each product is compacted into a 16-bit multiple-input signature register (MISR), and the final signature is compared against a golden value. It sits between the test-mode top level and the LFSR/multiplier pair, and owns the LFSR `seed_b`/`shift` controls. The LFSR `q` drives the multiplier operands directly.

## Interface
- `N_PATTERNS`, default 255: patterns applied per run, range 1..255.
- `GOLDEN_SIG`, default 16'h0000: expected final signature.
- `MUL_TIMEOUT`, default 15: maximum WAIT cycles allowed per multiplication (only with the watchdog compiled in).

- `clk` in 1: rising-edge clock.
- `rst_b` in 1: asynchronous, active-low reset.
- `bist_start` in 1: level request to start a run.
- `lfsr_seed_b` out 1: to LFSR `seed_b`; low reloads the seed 8'hFF.
- `lfsr_shift` out 1: to LFSR `shift`.
- `mul_start` out 1: one-cycle multiplier launch pulse.
- `mul_done` in 1: multiplier result valid.
- `mul_product` in 16: multiplier result.
- `busy` out 1: a run is in progress.
- `done` out 1: results valid.
- `pass` out 1: signature matched `GOLDEN_SIG` and no timeout occurred.
- `timeout` out 1: the watchdog fired.
- `signature` out 16: MISR contents.
- `pat_count` out 8: patterns completed.

## Operation
- All outputs are registered (Moore).
- Reset values:
  - state IDLE
  - `lfsr_seed_b`=1
  - `lfsr_shift`, `mul_start`, `busy`, `done`, `pass`, `timeout` = 0
  - `signature`=16'h0000, `pat_count`=0
- **IDLE**: when `bist_start`=1, go to SEED.
- **SEED**:
  - `lfsr_seed_b`=0 and `busy`=1.
  - Clear `signature`, `pat_count`, `done`, `pass`, `timeout`.
  - Go to LAUNCH.
- **LAUNCH**: `mul_start`=1; go to WAIT.
- **WAIT**:
  - On `mul_done`=1, compact `mul_product` into the MISR and go to SHIFT.
  - Otherwise increment the watchdog count.
- **SHIFT**:
  - `lfsr_shift`=1 and `pat_count`+1.
  - If the new count equals `N_PATTERNS`, go to CHECK; else go to LAUNCH.
- **CHECK**: `pass` = (`signature` == `GOLDEN_SIG`); go to DONE.
- **DONE**:
  - `done`=1 and `busy`=0.
  - Results hold; return to IDLE when `bist_start`=0.
  - Results remain visible in IDLE until the next SEED.
- MISR, polynomial x^16+x^12+x^5+1, with fb = `signature`[15]:
  - next[i] = sig[i-1] ^ p[i], except:
  - next[0] = fb ^ p[0]
  - next[5] = sig[4] ^ fb ^ p[5]
  - next[12] = sig[11] ^ fb ^ p[12]
- `pat_count` is 8-bit and never wraps, since `N_PATTERNS` ≤ 255.
- Boundary conditions:
  - `bist_start` changes outside IDLE and DONE are ignored.
  - `mul_done` is sampled only in WAIT; a stale `mul_done` in other states is ignored.
  - `rst_b` low mid-run: immediate return to reset values; the LFSR is not re-seeded until the next SEED.

## Timing
- `lfsr_seed_b` low for exactly one cycle.
- `mul_start` high for exactly one cycle per pattern.
- `lfsr_shift` high for exactly one cycle per pattern.
- The LFSR steps only after its product is captured, so operands are stable for the entire multiplication.
- Per-pattern cost: 3 + k cycles, where k is the number of WAIT cycles before `mul_done` (k ≥ 0 when `mul_done` is present on WAIT entry).
- Run length, `bist_start` sample to `done`=1: 1 (SEED) + N×(3+k) + 1 (CHECK) + 1 edge.
- `pass` and `done` update on the same edge that enters DONE.

## Configuration
- Macro `BIST_WATCHDOG_EN`.
- **Defined**:
  - A 4-bit+ WAIT counter is cleared on LAUNCH.
  - If it reaches `MUL_TIMEOUT` without `mul_done`, go directly to DONE with `timeout`=1 and `pass`=0; `signature` and `pat_count` freeze.
- **Undefined**:
  - No counter is implemented and WAIT waits indefinitely.
  - `timeout` is tied to 0.

## Test plan
- **Reset**: assert `rst_b`=0 mid-WAIT -> all outputs at reset values in the same cycle; `lfsr_seed_b`=1.
- **MISR vectors**, `N_PATTERNS`=3, products 16'h8000, 16'h0000, 16'h0000:
  - `signature` goes 16'h8000 -> 16'h1021 -> 16'h2042.
  - `pat_count`=3, `done`=1.
- **Handshake**, `N_PATTERNS`=2 with `mul_done` returned 2 cycles after each `mul_start`:
  - Exactly 2 `mul_start` and 2 `lfsr_shift` pulses and 1 `lfsr_seed_b` pulse.
  - `done` 13 cycles after `bist_start`.
- **Pass/fail**, golden model with the real multiplier and `N_PATTERNS`=255:
  - `GOLDEN_SIG` set to the model value -> `pass`=1.
  - Product bit 0 forced stuck-at-1 -> `pass`=0.
- **Watchdog** (`BIST_WATCHDOG_EN`, `MUL_TIMEOUT`=15), `mul_done` held 0 -> `timeout`=1, `pass`=0, `done`=1 after 15 WAIT cycles. Without the macro -> `busy` stays 1.
- **Restart**: hold `bist_start`=1 through DONE -> no restart. Drop it, then reassert -> SEED clears `signature` to 0 and a fresh run gives an identical signature.

Source files
------------

// File: rtl/bist_controller.sv
// Booth-multiplier BIST sequencer: seeds/steps the pattern LFSR, launches one multiply per pattern,
// compacts each product into a 16-bit MISR and checks the signature. Watchdog built with `BIST_WATCHDOG_EN.
module bist_controller #(
  parameter int unsigned   N_PATTERNS  = 255,
  parameter logic [15:0]   GOLDEN_SIG  = 16'h0000,
  parameter int unsigned   MUL_TIMEOUT = 15,
  localparam int unsigned  SIG_W       = 16,
  localparam int unsigned  CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             bist_start,
  output logic             lfsr_seed_b,
  output logic             lfsr_shift,
  output logic             mul_start,
  input  logic             mul_done,
  input  logic [SIG_W-1:0] mul_product,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] pat_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_LAUNCH, S_WAIT, S_SHIFT, S_CHECK, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic             seed_b_nxt, shift_nxt, start_nxt;
  logic             busy_nxt, done_nxt, pass_nxt;
  logic [SIG_W-1:0] sig_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // MISR step for x^16 + x^12 + x^5 + 1, feedback taken from the MSB
  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] p);
    logic [SIG_W-1:0] n;
    n     = {sig[SIG_W-2:0], sig[SIG_W-1]} ^ p;
    n[5]  = n[5]  ^ sig[SIG_W-1];
    n[12] = n[12] ^ sig[SIG_W-1];
    return n;
  endfunction

`ifdef BIST_WATCHDOG_EN
  localparam int unsigned WD_W = (MUL_TIMEOUT > 15) ? $clog2(MUL_TIMEOUT + 1) : 4;
  logic [WD_W-1:0] wd_cnt, wd_nxt;
  logic            timeout_q, timeout_nxt;
  assign timeout = timeout_q;
`else
  // watchdog not built: WAIT never gives up
  assign timeout = 1'b0 & (MUL_TIMEOUT != 0);
`endif

  // next-state and next registered-output values
  always_comb begin
    state_nxt  = state;
    seed_b_nxt = 1'b1;
    shift_nxt  = 1'b0;
    start_nxt  = 1'b0;
    busy_nxt   = busy;
    done_nxt   = done;
    pass_nxt   = pass;
    sig_nxt    = signature;
    cnt_nxt    = pat_count;
`ifdef BIST_WATCHDOG_EN
    wd_nxt      = wd_cnt;
    timeout_nxt = timeout_q;
`endif
    case (state)
      S_IDLE: begin
        if (bist_start) begin
          state_nxt  = S_SEED;
          seed_b_nxt = 1'b0;
          busy_nxt   = 1'b1;
          done_nxt   = 1'b0;
          pass_nxt   = 1'b0;
          sig_nxt    = '0;
          cnt_nxt    = '0;
`ifdef BIST_WATCHDOG_EN
          timeout_nxt = 1'b0;
`endif
        end
      end
      S_SEED: begin
        state_nxt = S_LAUNCH;
        start_nxt = 1'b1;
      end
      S_LAUNCH: begin
        state_nxt = S_WAIT;
`ifdef BIST_WATCHDOG_EN
        wd_nxt = '0;
`endif
      end
      S_WAIT: begin
        if (mul_done) begin
          state_nxt = S_SHIFT;
          shift_nxt = 1'b1;
          sig_nxt   = misr_next(signature, mul_product);
          cnt_nxt   = pat_count + CNT_W'(1);
`ifdef BIST_WATCHDOG_EN
        end else if (wd_cnt == WD_W'(MUL_TIMEOUT - 1)) begin
          state_nxt   = S_DONE;
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          pass_nxt    = 1'b0;
          timeout_nxt = 1'b1;
        end else begin
          wd_nxt = wd_cnt + WD_W'(1);
`endif
        end
      end
      S_SHIFT: begin
        if (pat_count == CNT_W'(N_PATTERNS)) begin
          state_nxt = S_CHECK;
        end else begin
          state_nxt = S_LAUNCH;
          start_nxt = 1'b1;
        end
      end
      S_CHECK: begin
        state_nxt = S_DONE;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        pass_nxt  = (signature == GOLDEN_SIG);
      end
      S_DONE: begin
        if (!bist_start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // state and Moore output registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= S_IDLE;
      lfsr_seed_b <= 1'b1;
      lfsr_shift  <= 1'b0;
      mul_start   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      signature   <= '0;
      pat_count   <= '0;
`ifdef BIST_WATCHDOG_EN
      wd_cnt      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      lfsr_seed_b <= seed_b_nxt;
      lfsr_shift  <= shift_nxt;
      mul_start   <= start_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      pass        <= pass_nxt;
      signature   <= sig_nxt;
      pat_count   <= cnt_nxt;
`ifdef BIST_WATCHDOG_EN
      wd_cnt      <= wd_nxt;
      timeout_q   <= timeout_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller: three instances (N=3 vectors, N=2 handshake/watchdog, N=255 golden)
// driven by a responder task that models the LFSR and a multiplier with configurable latency.
module tb_bist_controller;

  localparam int unsigned LANES = 3;

  // bench reference: LFSR x^8+x^6+x^5+x^4+1, signed square as the multiplier, MISR x^16+x^12+x^5+1
  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [15:0] square(input logic [7:0] q);
    logic signed [15:0] a;
    a = 16'($signed(q));
    return 16'(a * a);
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] p);
    logic [15:0] n;
    n = {s[14:0], s[15]} ^ p;
    n[5]  = n[5] ^ s[15];
    n[12] = n[12] ^ s[15];
    return n;
  endfunction

  function automatic logic [15:0] golden_sig(input int unsigned n, input bit stuck);
    logic [7:0]  q;
    logic [15:0] s;
    q = 8'hFF;
    s = 16'h0000;
    for (int unsigned i = 0; i < n; i++) begin
      s = misr_step(s, square(q) | 16'(stuck));
      q = lfsr_step(q);
    end
    return s;
  endfunction

  localparam logic [15:0] GOLD = golden_sig(255, 1'b0);

  logic        clk = 1'b0;
  logic        rst_b;
  logic        bist_start  [LANES];
  logic        mul_done    [LANES];
  logic [15:0] mul_product [LANES];
  logic        lfsr_seed_b [LANES];
  logic        lfsr_shift  [LANES];
  logic        mul_start   [LANES];
  logic        busy        [LANES];
  logic        done        [LANES];
  logic        pass        [LANES];
  logic        timeout     [LANES];
  logic [15:0] signature   [LANES];
  logic [7:0]  pat_count   [LANES];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] sig_hist [3];
  logic [15:0] seed_sig;

  always #5 clk = ~clk;

  bist_controller #(.N_PATTERNS(3), .GOLDEN_SIG(16'h2042), .MUL_TIMEOUT(15)) u_vec (
    .clk(clk), .rst_b(rst_b), .bist_start(bist_start[0]),
    .lfsr_seed_b(lfsr_seed_b[0]), .lfsr_shift(lfsr_shift[0]), .mul_start(mul_start[0]),
    .mul_done(mul_done[0]), .mul_product(mul_product[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .timeout(timeout[0]), .signature(signature[0]), .pat_count(pat_count[0]));

  bist_controller #(.N_PATTERNS(2), .GOLDEN_SIG(16'h0000), .MUL_TIMEOUT(15)) u_hs (
    .clk(clk), .rst_b(rst_b), .bist_start(bist_start[1]),
    .lfsr_seed_b(lfsr_seed_b[1]), .lfsr_shift(lfsr_shift[1]), .mul_start(mul_start[1]),
    .mul_done(mul_done[1]), .mul_product(mul_product[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .timeout(timeout[1]), .signature(signature[1]), .pat_count(pat_count[1]));

  bist_controller #(.N_PATTERNS(255), .GOLDEN_SIG(GOLD), .MUL_TIMEOUT(15)) u_gold (
    .clk(clk), .rst_b(rst_b), .bist_start(bist_start[2]),
    .lfsr_seed_b(lfsr_seed_b[2]), .lfsr_shift(lfsr_shift[2]), .mul_start(mul_start[2]),
    .mul_done(mul_done[2]), .mul_product(mul_product[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .timeout(timeout[2]), .signature(signature[2]), .pat_count(pat_count[2]));

  // Starts a run on one lane and answers each mul_start after lat WAIT cycles until done or budget.
  // bist_start is pulsed low mid-run, which the controller must ignore.
  task automatic run(input int ln, input int lat, input bit tab, input bit stuck, input bit stale,
                     input int max_cyc, output bit finished, output int cyc,
                     output int n_start, output int n_shift, output int n_seed);
    logic [7:0] q;
    int         wcnt;
    int         pidx;
    bit         pending;
    q = 8'h00; wcnt = 0; pidx = 0; pending = 1'b0;
    finished = 1'b0; cyc = 0; n_start = 0; n_shift = 0; n_seed = 0;
    bist_start[ln] = 1'b1;
    while (!finished && cyc < max_cyc) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) seed_sig = signature[ln];
      if (cyc == 4) bist_start[ln] = 1'b0;
      if (cyc == 5) bist_start[ln] = 1'b1;
      if (!lfsr_seed_b[ln]) begin
        n_seed++;
        q = 8'hFF;
      end else if (lfsr_shift[ln]) begin
        if (n_shift < 3) sig_hist[n_shift] = signature[ln];
        n_shift++;
        q = lfsr_step(q);
      end
      if (done[ln]) begin
        finished = 1'b1;
      end else if (mul_start[ln]) begin
        n_start++;
        pending = 1'b1;
        wcnt = 0;
        mul_done[ln] = 1'b0;
      end else if (pending) begin
        if (wcnt >= lat) begin
          mul_product[ln] = (tab ? ((pidx == 0) ? 16'h8000 : 16'h0000) : square(q)) | 16'(stuck);
          mul_done[ln] = 1'b1;
          pending = 1'b0;
          pidx++;
        end else begin
          wcnt++;
        end
      end else if (!stale) begin
        mul_done[ln] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    for (int l = 0; l < int'(LANES); l++) begin
      n_checks++;
      if ({lfsr_seed_b[l], lfsr_shift[l], mul_start[l], busy[l], done[l], pass[l], timeout[l],
           signature[l], pat_count[l]} !== {1'b1, 6'b0, 16'h0000, 8'h00}) begin
        n_fail++;
        $display("FAIL reset_values lane %0d: got seed_b=%b shift=%b start=%b busy=%b done=%b pass=%b to=%b sig=%h cnt=%h, want 1 0 0 0 0 0 0 0000 00",
                 l, lfsr_seed_b[l], lfsr_shift[l], mul_start[l], busy[l], done[l], pass[l],
                 timeout[l], signature[l], pat_count[l]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit fin; int cyc, ns, nsh, nsd;
    run(2, 0, 1'b0, 1'b0, 1'b0, 8, fin, cyc, ns, nsh, nsd);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy[2], pat_count[2], signature[2]} !== {1'b1, 8'd2, 16'h0006}) begin
      n_fail++;
      $display("FAIL midrun_state: got busy=%b cnt=%0d sig=%h, want busy=1 cnt=2 sig=0006",
               busy[2], pat_count[2], signature[2]);
    end
    #2 rst_b = 1'b0;
    #1;
    n_checks++;
    if ({lfsr_seed_b[2], lfsr_shift[2], mul_start[2], busy[2], done[2], pass[2], timeout[2],
         signature[2], pat_count[2]} !== {1'b1, 6'b0, 16'h0000, 8'h00}) begin
      n_fail++;
      $display("FAIL midrun_reset: got seed_b=%b shift=%b start=%b busy=%b done=%b pass=%b to=%b sig=%h cnt=%h, want 1 0 0 0 0 0 0 0000 00",
               lfsr_seed_b[2], lfsr_shift[2], mul_start[2], busy[2], done[2], pass[2],
               timeout[2], signature[2], pat_count[2]);
    end
    bist_start[2] = 1'b0;
    mul_done[2] = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_misr_vectors();
    bit fin; int cyc, ns, nsh, nsd;
    run(0, 1, 1'b1, 1'b0, 1'b1, 100, fin, cyc, ns, nsh, nsd);
    n_checks++;
    if (!fin || cyc != 15) begin
      n_fail++;
      $display("FAIL misr_run_length: got finished=%b cycles=%0d, want 1 and 15", fin, cyc);
    end
    n_checks++;
    if ({sig_hist[0], sig_hist[1], sig_hist[2]} !== {16'h8000, 16'h1021, 16'h2042}) begin
      n_fail++;
      $display("FAIL misr_sequence: got %h %h %h, want 8000 1021 2042", sig_hist[0], sig_hist[1], sig_hist[2]);
    end
    n_checks++;
    if ({done[0], busy[0], pass[0], timeout[0], pat_count[0], signature[0]} !== {4'b1010, 8'd3, 16'h2042}) begin
      n_fail++;
      $display("FAIL misr_final: got done=%b busy=%b pass=%b to=%b cnt=%0d sig=%h, want 1 0 1 0 3 2042",
               done[0], busy[0], pass[0], timeout[0], pat_count[0], signature[0]);
    end
    n_checks++;
    if (ns != 3 || nsh != 3 || nsd != 1) begin
      n_fail++;
      $display("FAIL misr_pulses: got start=%0d shift=%0d seed=%0d, want 3 3 1", ns, nsh, nsd);
    end
  endtask

  task automatic test_restart();
    bit fin; int cyc, ns, nsh, nsd;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if ({done[0], busy[0], signature[0]} !== {2'b10, 16'h2042}) begin
      n_fail++;
      $display("FAIL restart_hold_done: got done=%b busy=%b sig=%h, want 1 0 2042", done[0], busy[0], signature[0]);
    end
    bist_start[0] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if ({done[0], busy[0], pass[0], signature[0]} !== {3'b101, 16'h2042}) begin
      n_fail++;
      $display("FAIL restart_idle_results: got done=%b busy=%b pass=%b sig=%h, want 1 0 1 2042",
               done[0], busy[0], pass[0], signature[0]);
    end
    run(0, 1, 1'b1, 1'b0, 1'b1, 100, fin, cyc, ns, nsh, nsd);
    n_checks++;
    if (seed_sig !== 16'h0000) begin
      n_fail++;
      $display("FAIL restart_seed_clear: got sig=%h in SEED, want 0000", seed_sig);
    end
    n_checks++;
    if (!fin || cyc != 15 || signature[0] !== 16'h2042 || pass[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_rerun: got finished=%b cycles=%0d sig=%h pass=%b, want 1 15 2042 1",
               fin, cyc, signature[0], pass[0]);
    end
  endtask

  task automatic test_handshake();
    bit fin; int cyc, ns, nsh, nsd;
    run(1, 2, 1'b0, 1'b0, 1'b1, 100, fin, cyc, ns, nsh, nsd);
    n_checks++;
    if (!fin || cyc != 13) begin
      n_fail++;
      $display("FAIL hs_latency: got finished=%b cycles=%0d, want 1 and 13", fin, cyc);
    end
    n_checks++;
    if (ns != 2 || nsh != 2 || nsd != 1) begin
      n_fail++;
      $display("FAIL hs_pulses: got start=%0d shift=%0d seed=%0d, want 2 2 1", ns, nsh, nsd);
    end
    n_checks++;
    if ({done[1], busy[1], timeout[1], pat_count[1]} !== {3'b100, 8'd2}) begin
      n_fail++;
      $display("FAIL hs_final: got done=%b busy=%b to=%b cnt=%0d, want 1 0 0 2",
               done[1], busy[1], timeout[1], pat_count[1]);
    end
  endtask

  task automatic test_pass_fail();
    bit fin; int cyc, ns, nsh, nsd;
    run(2, 1, 1'b0, 1'b0, 1'b0, 3000, fin, cyc, ns, nsh, nsd);
    n_checks++;
    if (!fin || cyc != 1023 || ns != 255) begin
      n_fail++;
      $display("FAIL gold_run: got finished=%b cycles=%0d starts=%0d, want 1 1023 255", fin, cyc, ns);
    end
    n_checks++;
    if ({pass[2], timeout[2], pat_count[2], signature[2]} !== {2'b10, 8'd255, GOLD}) begin
      n_fail++;
      $display("FAIL gold_pass: got pass=%b to=%b cnt=%0d sig=%h, want 1 0 255 %h",
               pass[2], timeout[2], pat_count[2], signature[2], GOLD);
    end
    bist_start[2] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    run(2, 1, 1'b0, 1'b1, 1'b0, 3000, fin, cyc, ns, nsh, nsd);
    n_checks++;
    if (!fin || pass[2] !== 1'b0 || signature[2] !== golden_sig(255, 1'b1)) begin
      n_fail++;
      $display("FAIL stuck_fail: got finished=%b pass=%b sig=%h, want 1 0 %h",
               fin, pass[2], signature[2], golden_sig(255, 1'b1));
    end
  endtask

  task automatic test_watchdog();
    bit fin; int cyc, ns, nsh, nsd;
    bist_start[1] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    run(1, 1000, 1'b0, 1'b0, 1'b0, 40, fin, cyc, ns, nsh, nsd);
    n_checks++;
    if (ns != 1 || nsd != 1) begin
      n_fail++;
      $display("FAIL wd_pulses: got start=%0d seed=%0d, want 1 1", ns, nsd);
    end
`ifdef BIST_WATCHDOG_EN
    n_checks++;
    if (!fin || cyc != 18) begin
      n_fail++;
      $display("FAIL wd_latency: got finished=%b cycles=%0d, want 1 and 18", fin, cyc);
    end
    n_checks++;
    if ({done[1], busy[1], pass[1], timeout[1], pat_count[1], signature[1]} !== {4'b1001, 8'd0, 16'h0000}) begin
      n_fail++;
      $display("FAIL wd_final: got done=%b busy=%b pass=%b to=%b cnt=%0d sig=%h, want 1 0 0 1 0 0000",
               done[1], busy[1], pass[1], timeout[1], pat_count[1], signature[1]);
    end
`else
    n_checks++;
    if (fin || {busy[1], done[1], timeout[1]} !== 3'b100) begin
      n_fail++;
      $display("FAIL nowd_hang: got finished=%b busy=%b done=%b to=%b after %0d cycles, want 0 1 0 0",
               fin, busy[1], done[1], timeout[1], cyc);
    end
`endif
  endtask

  initial begin
    rst_b = 1'b1;
    for (int l = 0; l < int'(LANES); l++) begin
      bist_start[l]  = 1'b0;
      mul_done[l]    = 1'b0;
      mul_product[l] = 16'h0000;
    end
    #2 rst_b = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    test_reset_mid_run();
    test_misr_vectors();
    test_restart();
    test_handshake();
    test_pass_fail();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
